// File: rtl/wb_arbiter_4_masters_rr_if.sv
// wb_arbiter_4_masters_rr_if: Wishbone signals between four masters, the arbiter and one slave
//   i_mN_we/stb/cyc/sel/adr/dat : request from master N
//   o_mN_dat/ack/int            : read data, acknowledge, interrupt back to master N
//   o_s_*                       : request muxed onto the slave
//   i_s_dat/ack/int             : slave response
//   o_grant, o_timeout          : one-hot grant and watchdog abort pulse (status)
//   modport slave  : arbiter view (consumes requests, drives the slave port and returns)
//   modport master : environment view (masters plus slave model)
interface wb_arbiter_4_masters_rr_if;
    logic        i_m0_we, i_m1_we, i_m2_we, i_m3_we;
    logic        i_m0_stb, i_m1_stb, i_m2_stb, i_m3_stb;
    logic        i_m0_cyc, i_m1_cyc, i_m2_cyc, i_m3_cyc;
    logic [3:0]  i_m0_sel, i_m1_sel, i_m2_sel, i_m3_sel;
    logic [31:0] i_m0_adr, i_m1_adr, i_m2_adr, i_m3_adr;
    logic [31:0] i_m0_dat, i_m1_dat, i_m2_dat, i_m3_dat;
    logic [31:0] o_m0_dat, o_m1_dat, o_m2_dat, o_m3_dat;
    logic        o_m0_ack, o_m1_ack, o_m2_ack, o_m3_ack;
    logic        o_m0_int, o_m1_int, o_m2_int, o_m3_int;
    logic        o_s_we, o_s_stb, o_s_cyc;
    logic [3:0]  o_s_sel;
    logic [31:0] o_s_adr, o_s_dat, i_s_dat;
    logic        i_s_ack, i_s_int;
    logic [3:0]  o_grant;
    logic        o_timeout;
    modport slave (
        input  i_m0_we, i_m1_we, i_m2_we, i_m3_we, i_m0_stb, i_m1_stb, i_m2_stb, i_m3_stb,
               i_m0_cyc, i_m1_cyc, i_m2_cyc, i_m3_cyc, i_m0_sel, i_m1_sel, i_m2_sel, i_m3_sel,
               i_m0_adr, i_m1_adr, i_m2_adr, i_m3_adr, i_m0_dat, i_m1_dat, i_m2_dat, i_m3_dat,
               i_s_dat, i_s_ack, i_s_int,
        output o_m0_dat, o_m1_dat, o_m2_dat, o_m3_dat, o_m0_ack, o_m1_ack, o_m2_ack, o_m3_ack,
               o_m0_int, o_m1_int, o_m2_int, o_m3_int, o_s_we, o_s_stb, o_s_cyc, o_s_sel,
               o_s_adr, o_s_dat, o_grant, o_timeout
    );
    modport master (
        output i_m0_we, i_m1_we, i_m2_we, i_m3_we, i_m0_stb, i_m1_stb, i_m2_stb, i_m3_stb,
               i_m0_cyc, i_m1_cyc, i_m2_cyc, i_m3_cyc, i_m0_sel, i_m1_sel, i_m2_sel, i_m3_sel,
               i_m0_adr, i_m1_adr, i_m2_adr, i_m3_adr, i_m0_dat, i_m1_dat, i_m2_dat, i_m3_dat,
               i_s_dat, i_s_ack, i_s_int,
        input  o_m0_dat, o_m1_dat, o_m2_dat, o_m3_dat, o_m0_ack, o_m1_ack, o_m2_ack, o_m3_ack,
               o_m0_int, o_m1_int, o_m2_int, o_m3_int, o_s_we, o_s_stb, o_s_cyc, o_s_sel,
               o_s_adr, o_s_dat, o_grant, o_timeout
    );
endinterface

// File: rtl/wb_arbiter_4_masters_rr.sv
// wb_arbiter_4_masters_rr: round-robin Wishbone arbiter sharing one slave among four masters
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : wb_arbiter_4_masters_rr_if.slave (master requests/returns, slave port, o_grant, o_timeout)
//   Macro ARB_TIMEOUT_EN adds a watchdog that aborts a grant after TIMEOUT_CYCLES unacked strobes.
module wb_arbiter_4_masters_rr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rst,
    wb_arbiter_4_masters_rr_if.slave bus
);
`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
    typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif
    state_t      state, state_nx;
    logic [3:0]  cyc, stb, we, req, pick, grant, grant_nx;
    logic [3:0]  sel [4];
    logic [31:0] adr [4], wdat [4];
    logic [1:0]  ptr, ptr_nx, gidx, k;
    logic        has;
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end
    assign cyc  = {bus.i_m3_cyc, bus.i_m2_cyc, bus.i_m1_cyc, bus.i_m0_cyc};
    assign stb  = {bus.i_m3_stb, bus.i_m2_stb, bus.i_m1_stb, bus.i_m0_stb};
    assign we   = {bus.i_m3_we, bus.i_m2_we, bus.i_m1_we, bus.i_m0_we};
    assign sel  = '{bus.i_m0_sel, bus.i_m1_sel, bus.i_m2_sel, bus.i_m3_sel};
    assign adr  = '{bus.i_m0_adr, bus.i_m1_adr, bus.i_m2_adr, bus.i_m3_adr};
    assign wdat = '{bus.i_m0_dat, bus.i_m1_dat, bus.i_m2_dat, bus.i_m3_dat};
    // grant is one-hot, so its index is a plain OR-encode
    assign gidx = {grant[3] | grant[2], grant[3] | grant[1]};
    assign has  = |grant;
    assign bus.o_s_cyc = has & cyc[gidx];
    assign bus.o_s_stb = has & stb[gidx];
    assign bus.o_s_we  = has & we[gidx];
    assign bus.o_s_sel = has ? sel[gidx] : '0;
    assign bus.o_s_adr = has ? adr[gidx] : '0;
    assign bus.o_s_dat = has ? wdat[gidx] : '0;
    assign bus.o_m0_ack = bus.i_s_ack & grant[0];
    assign bus.o_m1_ack = bus.i_s_ack & grant[1];
    assign bus.o_m2_ack = bus.i_s_ack & grant[2];
    assign bus.o_m3_ack = bus.i_s_ack & grant[3];
    assign bus.o_m0_dat = grant[0] ? bus.i_s_dat : '0;
    assign bus.o_m1_dat = grant[1] ? bus.i_s_dat : '0;
    assign bus.o_m2_dat = grant[2] ? bus.i_s_dat : '0;
    assign bus.o_m3_dat = grant[3] ? bus.i_s_dat : '0;
    assign bus.o_m0_int = bus.i_s_int;
    assign bus.o_m1_int = bus.i_s_int;
    assign bus.o_m2_int = bus.i_s_int;
    assign bus.o_m3_int = bus.i_s_int;
    assign bus.o_grant  = grant;
    // descending scan so the requester closest to ptr is written last and wins
    always_comb begin
        pick = '0;
        k = '0;
        for (int i = 3; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) pick = 4'b1 << k;
        end
    end
`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic [3:0]  mask;
    logic        stall, abort, timeout;
    assign stall = state == BUSY && bus.o_s_stb && !bus.i_s_ack;
    assign abort = stall && cyc[gidx] && cnt == 16'(TIMEOUT_CYCLES - 1);
    assign req   = cyc & ~mask;
    assign bus.o_timeout = timeout;
    // a master stays masked after an abort until it lets its cyc fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mask    <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= stall && state_nx == BUSY ? cnt + 16'd1 : '0;
            mask    <= (mask & cyc) | (abort ? grant : 4'b0);
            timeout <= abort;
        end
    end
`else
    assign req = cyc;
    assign bus.o_timeout = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            if (|pick) begin
                grant_nx = pick;
                state_nx = BUSY;
            end
        end else if (state == BUSY) begin
            if (!cyc[gidx]) begin
                grant_nx = '0;
                ptr_nx   = gidx + 2'd1;
                state_nx = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (abort) begin
                grant_nx = '0;
                ptr_nx   = gidx + 2'd1;
                state_nx = ABORT;
            end
`endif
        end else begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            ptr   <= ptr_nx;
        end
    end
endmodule
